// File: rtl/unidad_fetch_param.sv
// rtl/unidad_fetch_param.sv - parametrised PC, return stack and instruction register with tick-paced fetch handshake
module unidad_fetch_param #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 9,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int               LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Tick,
    input  logic [INSTR_W-1:0] i_Instr,
    input  logic               i_Instr_valid,
    input  logic               i_Jump,
    input  logic               i_Call,
    input  logic               i_Ret,
    input  logic [ADDR_W-1:0]  i_Target,
    input  logic               i_Halt,
    input  logic               i_Resume,
    output logic [ADDR_W-1:0]  o_Fetch_addr,
    output logic               o_Fetch_req,
    output logic [INSTR_W-1:0] o_Instr,
    output logic               o_Instr_valid,
    output logic [ADDR_W-1:0]  o_Return_addr,
    output logic [LVL_W-1:0]   o_Stack_level,
    output logic               o_Overflow,
    output logic               o_Underflow,
    output logic               o_Halted
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              stack_empty;
    logic              stack_full;
    logic              in_exec;
    logic              take_ret;
    logic              take_call;
    logic              err_under;
    logic              err_over;

    assign pc_inc      = pc + 1'b1;
    assign top_idx     = IDX_W'(level - 1'b1);
    assign push_idx    = IDX_W'(level);
    assign stack_empty = (level == '0);
    assign stack_full  = (level == LVL_W'(STACK_DEPTH));
    assign in_exec     = (state == S_EXEC);

    // Decision priority in the execute cycle: return, then call, then jump.
    assign take_ret  = in_exec & i_Ret;
    assign take_call = in_exec & ~i_Ret & i_Call;
    assign err_under = take_ret & stack_empty;
    assign err_over  = take_call & stack_full;

    assign o_Fetch_addr  = pc;
    assign o_Stack_level = level;
    assign o_Return_addr = stack_empty ? '0 : stack_mem[top_idx];

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_Halt) begin
                    state_next = S_HALT;
                end else if (i_Tick) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_Instr_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (err_under || err_over) begin
                    state_next = S_FAULT;
                end else if (i_Halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HALT: begin
                if (i_Resume) begin
                    state_next = S_IDLE;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Fetch_req   = (state == S_REQ);
        o_Instr_valid = (state == S_EXEC);
        o_Halted      = (state == S_HALT);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            pc          <= RESET_ADDR;
            o_Instr     <= '0;
            level       <= '0;
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            if (state == S_REQ && i_Instr_valid) begin
                o_Instr <= i_Instr;
            end
            // A faulting return or call leaves PC and stack untouched.
            if (in_exec) begin
                if (take_ret) begin
                    if (stack_empty) begin
                        o_Underflow <= 1'b1;
                    end else begin
                        pc    <= stack_mem[top_idx];
                        level <= level - 1'b1;
                    end
                end else if (take_call) begin
                    if (stack_full) begin
                        o_Overflow <= 1'b1;
                    end else begin
                        stack_mem[push_idx] <= pc_inc;
                        pc                  <= i_Target;
                        level               <= level + 1'b1;
                    end
                end else if (i_Jump) begin
                    pc <= i_Target;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

endmodule
